// File: rtl/hazard_controller.sv
// Hazard/forwarding controller for the 5-stage MIPS core: EX/MEM/WB scoreboard, EX bypass select,
// load-use stall/bubble and a saturating stall-cycle counter. Define BRANCH_FORWARD_EN for ID-stage branch compare support.
module hazard_controller #(
    parameter int ADDR_W      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      rs_D,
    input  logic [ADDR_W-1:0]      rt_D,
    input  logic [ADDR_W-1:0]      rd_D,
    input  logic                   regdst_D,
    input  logic                   regwrite_D,
    input  logic                   memtoreg_D,
    input  logic                   branch_D,
    input  logic                   flush_D,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic                   stall_F,
    output logic                   stall_D,
    output logic                   flush_E,
    output logic [STALL_CNT_W-1:0] stall_count
`ifdef BRANCH_FORWARD_EN
    ,
    output logic                   forward_aD,
    output logic                   forward_bD
`endif
);

    localparam logic [ADDR_W-1:0]      REG_ZERO = '0;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]             FWD_REG  = 2'b00;
    localparam logic [1:0]             FWD_WB   = 2'b01;
    localparam logic [1:0]             FWD_MEM  = 2'b10;

    // Scoreboard slots: E (ID/EX), M (EX/MEM), W (MEM/WB)
    logic              e_valid, e_regwrite, e_memtoreg;
    logic [ADDR_W-1:0] e_dest, rs_e, rt_e;
    logic              m_valid, m_regwrite, m_memtoreg;
    logic [ADDR_W-1:0] m_dest;
    logic              w_valid, w_regwrite;
    logic [ADDR_W-1:0] w_dest;

    logic [ADDR_W-1:0] dest_d;
    logic              load_use;
    logic              branch_stall;
    logic              stall;
    logic              capture_d;

    function automatic logic [1:0] bypass_sel(
        input logic [ADDR_W-1:0] src,
        input logic              mem_hit_ok,
        input logic [ADDR_W-1:0] mem_dest,
        input logic              wb_hit_ok,
        input logic [ADDR_W-1:0] wb_dest
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != REG_ZERO) begin
            if (mem_hit_ok && (mem_dest == src)) begin
                sel = FWD_MEM;
            end else if (wb_hit_ok && (wb_dest == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    function automatic logic dest_conflict(
        input logic [ADDR_W-1:0] dest,
        input logic [ADDR_W-1:0] src_a,
        input logic [ADDR_W-1:0] src_b
    );
        return (dest != REG_ZERO) && ((dest == src_a) || (dest == src_b));
    endfunction

    assign dest_d = regdst_D ? rd_D : rt_D;

    always_comb begin
        load_use = e_valid && e_memtoreg && dest_conflict(e_dest, rs_D, rt_D);
    end

`ifdef BRANCH_FORWARD_EN
    // Branch compares in ID: wait for an ALU producer still in EX or a load still in MEM
    always_comb begin
        branch_stall = branch_D &&
                       ((e_valid && e_regwrite && dest_conflict(e_dest, rs_D, rt_D)) ||
                        (m_valid && m_memtoreg && dest_conflict(m_dest, rs_D, rt_D)));
    end

    always_comb begin
        forward_aD = m_valid && m_regwrite && (rs_D != REG_ZERO) && (m_dest == rs_D);
        forward_bD = m_valid && m_regwrite && (rt_D != REG_ZERO) && (m_dest == rt_D);
    end
`else
    logic unused_inputs;
    assign unused_inputs = branch_D ^ m_memtoreg;
    assign branch_stall  = 1'b0;
`endif

    assign stall     = load_use || branch_stall;
    assign capture_d = !stall && !flush_D;

    always_comb begin
        stall_F = stall;
        stall_D = stall;
        // Gated by reset so a pending flush_D cannot leak out while the core is held in reset
        flush_E = reset && (stall || flush_D);
    end

    always_comb begin
        forward_a = bypass_sel(rs_e, m_valid && m_regwrite, m_dest, w_valid && w_regwrite, w_dest);
        forward_b = bypass_sel(rt_e, m_valid && m_regwrite, m_dest, w_valid && w_regwrite, w_dest);
    end

    // A bubble clears the whole E slot so its stale sources cannot request a bypass
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid    <= 1'b0;
            e_regwrite <= 1'b0;
            e_memtoreg <= 1'b0;
            e_dest     <= REG_ZERO;
            rs_e       <= REG_ZERO;
            rt_e       <= REG_ZERO;
        end else if (capture_d) begin
            e_valid    <= 1'b1;
            e_regwrite <= regwrite_D;
            e_memtoreg <= memtoreg_D;
            e_dest     <= dest_d;
            rs_e       <= rs_D;
            rt_e       <= rt_D;
        end else begin
            e_valid    <= 1'b0;
            e_regwrite <= 1'b0;
            e_memtoreg <= 1'b0;
            e_dest     <= REG_ZERO;
            rs_e       <= REG_ZERO;
            rt_e       <= REG_ZERO;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid    <= 1'b0;
            m_regwrite <= 1'b0;
            m_memtoreg <= 1'b0;
            m_dest     <= REG_ZERO;
            w_valid    <= 1'b0;
            w_regwrite <= 1'b0;
            w_dest     <= REG_ZERO;
        end else begin
            m_valid    <= e_valid;
            m_regwrite <= e_regwrite;
            m_memtoreg <= e_memtoreg;
            m_dest     <= e_dest;
            w_valid    <= m_valid;
            w_regwrite <= m_regwrite;
            w_dest     <= m_dest;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized + directed bench for hazard_controller; reference model keeps a short history of
// instructions issued into EX and derives bypass/stall outcomes from the pipeline distance.
module tb_hazard_controller;

    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef BRANCH_FORWARD_EN
    localparam int OW = 13;
`else
    localparam int OW = 11;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] rs_D = '0, rt_D = '0, rd_D = '0;
    logic          regdst_D = 1'b0, regwrite_D = 1'b0, memtoreg_D = 1'b0;
    logic          branch_D = 1'b0, flush_D = 1'b0;
    logic [1:0]    forward_a, forward_b;
    logic          stall_F, stall_D, flush_E;
    logic [CW-1:0] stall_count;
    logic [OW-1:0] act;
`ifdef BRANCH_FORWARD_EN
    logic          forward_aD, forward_bD;
    assign act = {forward_a, forward_b, stall_F, stall_D, flush_E, stall_count, forward_aD, forward_bD};
`else
    assign act = {forward_a, forward_b, stall_F, stall_D, flush_E, stall_count};
`endif

    hazard_controller #(.ADDR_W(AW), .STALL_CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .rd_D(rd_D),
        .regdst_D(regdst_D), .regwrite_D(regwrite_D), .memtoreg_D(memtoreg_D),
        .branch_D(branch_D), .flush_D(flush_D),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
        .stall_count(stall_count)
`ifdef BRANCH_FORWARD_EN
        , .forward_aD(forward_aD), .forward_bD(forward_bD)
`endif
    );

    always #5 clk = ~clk;

    // hist[0] = instruction now in EX, hist[1] = MEM, hist[2] = WB
    typedef struct {
        bit            v;
        bit            rw;
        bit            mtr;
        logic [AW-1:0] dest;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
    } instr_t;

    instr_t        hist[$];
    int            cnt;
    int            tests = 0;
    int            fails = 0;
    bit            last_stall;
    logic [OW-1:0] exp_q[$];

    function automatic instr_t bubble();
        instr_t b;
        b.v = 0; b.rw = 0; b.mtr = 0; b.dest = '0; b.rs = '0; b.rt = '0;
        return b;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(bubble());
        cnt = 0;
    endfunction

    // Nearest older producer wins: distance 1 is MEM, distance 2 is WB
    function automatic logic [1:0] model_fwd(logic [AW-1:0] x);
        if (x == 0) return 2'b00;
        for (int d = 1; d <= 2; d++)
            if (hist[d].v && hist[d].rw && hist[d].dest == x) return (d == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic bit reads(instr_t p, logic [AW-1:0] a, logic [AW-1:0] b);
        return (p.dest != 0) && (p.dest == a || p.dest == b);
    endfunction

    function automatic bit model_stall(logic [AW-1:0] rs, logic [AW-1:0] rt, bit br);
        bit s;
        s = hist[0].v && hist[0].mtr && reads(hist[0], rs, rt);
`ifdef BRANCH_FORWARD_EN
        s = s || (br && ((hist[0].v && hist[0].rw && reads(hist[0], rs, rt)) ||
                         (hist[1].v && hist[1].mtr && reads(hist[1], rs, rt))));
`else
        if (br) s = s || 1'b0;
`endif
        return s;
    endfunction

    function automatic logic [OW-1:0] predict(logic [AW-1:0] rs, logic [AW-1:0] rt, bit st, bit fl, bit rst);
        logic [CW-1:0] c;
        bit            fe;
        c  = CW'(cnt);
        fe = (st || fl) && !rst;
`ifdef BRANCH_FORWARD_EN
        return {model_fwd(hist[0].rs), model_fwd(hist[0].rt), st, st, fe, c,
                hist[1].v && hist[1].rw && rs != 0 && hist[1].dest == rs,
                hist[1].v && hist[1].rw && rt != 0 && hist[1].dest == rt};
`else
        if (rs == rt) c = c;
        return {model_fwd(hist[0].rs), model_fwd(hist[0].rt), st, st, fe, c};
`endif
    endfunction

    task automatic drive_cycle(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                               input bit regdst, input bit rw, input bit mtr, input bit br,
                               input bit fl, input bit rst);
        bit     st;
        instr_t n;
        @(negedge clk);
        reset = !rst;
        rs_D = rs; rt_D = rt; rd_D = rd;
        regdst_D = regdst; regwrite_D = rw; memtoreg_D = mtr;
        branch_D = br; flush_D = fl;
        if (rst) model_reset();
        st = rst ? 1'b0 : model_stall(rs, rt, br);
        last_stall = st;
        exp_q.push_back(predict(rs, rt, st, fl, rst));
        @(posedge clk);
        if (!rst) begin
            n = bubble();
            if (!st && !fl) begin
                n.v = 1; n.rw = rw; n.mtr = mtr;
                n.dest = regdst ? rd : rt; n.rs = rs; n.rt = rt;
            end
            hist.push_front(n);
            void'(hist.pop_back());
            if (st && cnt < CMAX) cnt++;
        end
    endtask

    // Re-present a stalled instruction until the model lets it into EX
    task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input bit regdst, input bit rw, input bit mtr, input bit br, input bit fl);
        int g;
        drive_cycle(rs, rt, rd, regdst, rw, mtr, br, fl, 0);
        g = 0;
        while (last_stall && g < 4) begin
            drive_cycle(rs, rt, rd, regdst, rw, mtr, br, 0, 0);
            g++;
        end
    endtask

    task automatic nop();
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        logic [OW-1:0] e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL outputs t=%0t actual=%b expected=%b", $time, act, e);
            end
        end
    end

    initial begin
        logic [AW-1:0] rs, rt, rd;
        bit            regdst, rw, mtr, br, fl, rst;
        model_reset();
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        drive_cycle(3, 4, 5, 1, 1, 0, 0, 0, 1);

        // add $3 ; add $4,$3,$5 (MEM bypass) ; add $3 ; nop ; add $4,$3,$5 (WB bypass)
        issue(1, 2, 3, 1, 1, 0, 0, 0);
        issue(3, 5, 4, 1, 1, 0, 0, 0);
        nop(); nop();
        issue(1, 2, 3, 1, 1, 0, 0, 0);
        nop();
        issue(3, 5, 4, 1, 1, 0, 0, 0);
        nop(); nop();

        // lw $2 followed by a consumer of $2: one bubble, then WB bypass
        issue(0, 2, 0, 0, 1, 1, 0, 0);
        issue(2, 6, 8, 1, 1, 0, 0, 0);
        nop(); nop();

        // writes to $0 never bypass; lw $0 never stalls
        issue(1, 2, 0, 1, 1, 0, 0, 0);
        issue(1, 2, 0, 1, 1, 0, 0, 0);
        issue(0, 0, 9, 1, 1, 0, 0, 0);
        issue(0, 0, 0, 0, 1, 1, 0, 0);
        issue(0, 0, 10, 1, 1, 0, 0, 0);
        nop(); nop();

        // $7 written in both M and W: MEM wins
        issue(1, 2, 7, 1, 1, 0, 0, 0);
        issue(1, 2, 7, 1, 1, 0, 0, 0);
        issue(7, 7, 11, 1, 1, 0, 0, 0);
        nop(); nop();

        // flush together with load-use holds; flush alone squashes
        issue(0, 2, 0, 0, 1, 1, 0, 0);
        drive_cycle(2, 3, 12, 1, 1, 0, 0, 1, 0);
        issue(2, 3, 12, 1, 1, 0, 0, 0);
        drive_cycle(1, 1, 5, 1, 1, 0, 0, 1, 0);
        issue(5, 5, 6, 1, 1, 0, 0, 0);
        nop(); nop();

        // branch compare against a producer still in EX
        issue(1, 2, 3, 1, 1, 0, 0, 0);
        issue(3, 4, 0, 0, 0, 0, 1, 0);
        nop(); nop();

        // reset asserted in the middle of a load-use stall
        issue(0, 9, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        reset = 1'b1; rs_D = 9; rt_D = 0; rd_D = 1;
        regdst_D = 1; regwrite_D = 1; memtoreg_D = 0; branch_D = 0; flush_D = 1;
        exp_q.push_back(predict(9, 0, model_stall(9, 0, 0), 1, 0));
        #4 reset = 1'b0;
        #1;
        tests++;
        if (act !== '0) begin
            fails++;
            $display("FAIL reset_mid_stall actual=%b expected=0", act);
        end
        model_reset();
        @(posedge clk);
        drive_cycle(9, 0, 1, 1, 1, 0, 0, 1, 1);

        // enough load-use pairs to saturate the stall counter
        for (int i = 0; i < CMAX + 3; i++) begin
            issue(0, 2, 0, 0, 1, 1, 0, 0);
            issue(2, 0, 4, 1, 1, 0, 0, 0);
        end
        nop(); nop();

        for (int i = 0; i < 1500; i++) begin
            if (!last_stall) begin
                rs = AW'($urandom_range(0, 7));
                rt = AW'($urandom_range(0, 7));
                rd = AW'($urandom_range(0, 7));
                regdst = ($urandom_range(0, 1) == 1);
                rw     = ($urandom_range(0, 3) != 0);
                mtr    = rw && ($urandom_range(0, 2) == 0);
                br     = ($urandom_range(0, 5) == 0);
            end
            fl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 299) == 0);
            drive_cycle(rs, rt, rd, regdst, rw, mtr, br, fl, rst);
        end

        @(negedge clk);
        #5;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d expected=0 pending", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
